// File: rtl/march_controller.sv
// March C- sequencer for the MBIST engine: steps an external up/down address
// counter through six march elements and checks each read against its background.
module march_controller #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  cnt_ld,
   output logic                  cnt_ud,
   output logic                  cnt_cen,
   output logic [ADDR_WIDTH-1:0] cnt_din,
   input  logic [ADDR_WIDTH-1:0] cnt_q,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [2:0]            fail_elem
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RD,
      S_WR,
      S_CHK,
      S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   state_t                state;
   state_t                state_next;
   logic [2:0]            elem;
   logic [2:0]            elem_next;
   logic                  elem_down;
   logic                  last_addr;
   logic                  compare_en;
   logic                  miscompare;
   logic [DATA_WIDTH-1:0] read_val;
   logic [DATA_WIDTH-1:0] write_val;
   logic [ADDR_WIDTH-1:0] next_start;

   assign mem_addr   = cnt_q;
   assign elem_down  = (elem == 3'd3) || (elem == 3'd4);
   assign last_addr  = elem_down ? (cnt_q == '0) : (cnt_q == ADDR_LAST);
   assign read_val   = ((elem == 3'd2) || (elem == 3'd4)) ? '1 : '0;
   assign write_val  = ((elem == 3'd1) || (elem == 3'd3)) ? '1 : '0;
   // Start address of the element that follows the current one.
   assign next_start = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_LAST : '0;
   assign compare_en = ((state == S_WR) && (elem != 3'd0)) || (state == S_CHK);
   assign miscompare = compare_en && (mem_rdata != read_val);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         elem  <= '0;
      end else begin
         state <= state_next;
         elem  <= elem_next;
      end
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_next = state;
      elem_next  = elem;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next = S_LOAD;
               elem_next  = 3'd0;
            end
         end
         S_LOAD: state_next = S_WR;
         S_RD:   state_next = (elem == 3'd5) ? S_CHK : S_WR;
         S_WR: begin
            if (last_addr) begin
               state_next = S_RD;
               elem_next  = elem + 3'd1;
            end else begin
               state_next = (elem == 3'd0) ? S_WR : S_RD;
            end
         end
         S_CHK:   state_next = last_addr ? S_DONE : S_RD;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_ld    = 1'b0;
      cnt_ud    = 1'b0;
      cnt_cen   = 1'b0;
      cnt_din   = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         S_LOAD: begin
            cnt_ld  = 1'b1;
            cnt_cen = 1'b1;
         end
         S_RD: mem_re = 1'b1;
         S_WR: begin
            mem_we    = 1'b1;
            mem_wdata = write_val;
            cnt_cen   = 1'b1;
            // Reloading in the final write keeps the next element bubble-free.
            if (last_addr) begin
               cnt_ld  = 1'b1;
               cnt_din = next_start;
            end else begin
               cnt_ud = ~elem_down;
            end
         end
         S_CHK: begin
            cnt_cen = 1'b1;
            cnt_ud  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
      end else begin
         busy <= (state_next == S_LOAD) || (state_next == S_RD) ||
                 (state_next == S_WR)   || (state_next == S_CHK);
         done <= (state_next == S_DONE);
         if (state_next == S_LOAD) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
         end else if (miscompare) begin
            fail <= 1'b1;
            if (!fail) begin
               fail_addr <= cnt_q;
               fail_elem <= elem;
            end
         end
      end
   end

endmodule

// File: doc/march_controller.md
# march_controller

March C- test sequencer for the MBIST engine. It drives the external up/down address counter (`ld`/`u_d`/`cen`/`d_in`) and the memory-under-test control strobes, and checks every read against the expected data background. It reports done, pass/fail and the first failing address and element. It sits between the BIST start/status interface and the address counter plus SRAM.

## Interface
- `ADDR_WIDTH`, 10: address bits; must equal the counter `LENGTH`. N = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 8: memory word width.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled; begins a run when in IDLE or DONE.
- `cnt_ld`, `cnt_ud`, `cnt_cen` out 1 each: to counter `ld`, `u_d`, `cen`.
- `cnt_din` out ADDR_WIDTH: to counter `d_in`.
- `cnt_q` in ADDR_WIDTH: counter `q`; this is the current test address.
- `mem_addr` out ADDR_WIDTH: equals `cnt_q`, combinational.
- `mem_re`, `mem_we` out 1 each: memory read and write strobes. Synchronous memory with 1-cycle read latency.
- `mem_wdata` out DATA_WIDTH: all-0s or all-1s background.
- `mem_rdata` in DATA_WIDTH: read data, valid the cycle after `mem_re`.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held high in DONE.
- `fail` out 1: sticky, at least one miscompare in the current run.
- `fail_addr` out ADDR_WIDTH: address of the first miscompare.
- `fail_elem` out 3: element index (1..5) of the first miscompare.

## Operation
- **Elements (index `elem`):**
  - 0: up(w0)
  - 1: up(r0,w1)
  - 2: up(r1,w0)
  - 3: down(r0,w1)
  - 4: down(r1,w0)
  - 5: up(r0)
  - Up elements start at address 0; down elements start at N-1.
- **FSM states:** IDLE, LOAD, RD, WR, CHK, DONE.
- **Transitions:**
  - IDLE/DONE + `start` -> LOAD. LOAD also clears `fail`, `fail_addr`, `fail_elem` and sets `elem`=0.
  - LOAD: `cnt_ld`=1, `cnt_cen`=1, `cnt_din`=0. Next state is WR (elem 0).
  - RD: `mem_re`=1. Next state is WR for elems 1-4, CHK for elem 5.
  - WR: `mem_we`=1, `mem_wdata` = the element's write value.
    - Elems 1-4: also compares `mem_rdata` with the read value.
    - Elem 0: next address is WR. Elems 1-4: next address is RD.
  - CHK (elem 5 only): compares `mem_rdata` against 0.
- **Address step:** in the last cycle of each address (WR, or CHK), `cnt_cen`=1.
  - Not the last address: `cnt_ld`=0, `cnt_ud` = element direction.
  - Last address (N-1 going up, 0 going down):
    - If elem < 5: `cnt_ld`=1, `cnt_din` = start address of elem+1, `elem` increments, next state is the first op of the new element.
    - If elem = 5: next state is DONE.
- **Counter hold:** `cnt_cen`=0 in every other cycle, so the counter holds. Counter `cout` is unused.
- **Miscompare:** any bit differing from the expected word.
  - Sets `fail`.
  - If `fail` was 0, also captures `fail_addr` = `cnt_q` and `fail_elem` = `elem`.
  - The run continues to completion (no early stop).
- **`start` handling:** ignored while `busy`. A restart from DONE is allowed.
- **Status:** `busy` = 1 in LOAD/RD/WR/CHK. `done` = 1 only in DONE. Pass is `done & ~fail`.

## Timing
- **Reset values:** state IDLE, `elem` 0, and every output 0 (`cnt_*`, `mem_re`, `mem_we`, `mem_wdata`, `busy`, `done`, `fail`, `fail_addr`, `fail_elem`).
- **Reset mid-run:** returns to IDLE immediately; all status is cleared. Counter contents are don't-care because LOAD reinitialises them.
- **Output type:** strobes and counter controls are Moore, decoded from state, `elem` and `cnt_q`. Status flags are registered.
- **Run length:** `start` sampled at edge t0 gives LOAD in cycle t0+1.
  - Run length is 1 + N + 4·2N + 2N = 1 + 11N busy cycles.
  - `done` rises on the edge that ends the final CHK.
- **No bubbles:** there is no idle cycle between elements. The reload happens in the last op cycle.
- **Read-compare pairing:** the read issued in RD at address A is compared in the following WR/CHK cycle while `cnt_q` = A.

## Test plan
- **Clean run:** ADDR_WIDTH=3, DATA_WIDTH=8, fault-free memory, pulse `start`. Required response:
  - `busy` high for exactly 89 cycles, then `done`=1 and `fail`=0.
  - Address trace: elems 0-2 ascending 0..7, elems 3-4 descending 7..0, elem 5 ascending.
  - Final memory contents all 0x00.
- **Stuck-at-1 fault:** bit 0 of address 5 stuck at 1. Required response: `done`=1, `fail`=1, `fail_addr`=5, `fail_elem`=1. The capture is not overwritten by the later miscompares in elems 3 and 5.
- **Stuck-at-0 fault:** bit 7 of address 0 stuck at 0. Required response: `fail_elem`=2, `fail_addr`=0.
- **Reset mid-run:** assert `rst` in cycle 40. Required response:
  - All outputs 0 asynchronously.
  - A new `start` gives a clean 89-cycle run with `fail`=0.
- **Start while busy / restart:** hold `start` high throughout the run; there is no restart while `busy`. Then in DONE:
  - With `fail`=1 from a prior faulty run, a new `start` over fault-free memory clears `fail`.
  - The re-run ends with `fail`=0.
- **Element boundary:** at the elem2->elem3 transition, check `cnt_ld`=1 and `cnt_din`=7 in the same cycle as the final `mem_we` at address 7. The next cycle is RD at address 7.
